// File: rtl/ls_mem_ctrl.sv
// ls_mem_ctrl: serialises 1/2/4-byte load/store requests onto a byte-wide synchronous RAM
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   en_ls, r_nw         request valid (held until finish), 1 = read / 0 = write
//   ls_addr, ls_size    byte base address, byte count (1, 2 or 4; anything else means 4)
//   ls_data             store data, bytes taken LSB first
//   finish, ls_rdata    one-cycle completion pulse, zero-extended read word
//   mem_a, mem_dout     RAM byte address and write byte
//   mem_wr, mem_din     RAM write enable, read byte (valid the cycle after mem_a)
module ls_mem_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 17
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_ls,
    input  logic                      r_nw,
    input  logic [ADDR_WIDTH-1:0]     ls_addr,
    input  logic [7:0]                ls_size,
    input  logic [31:0]               ls_data,
    output logic                      finish,
    output logic [31:0]               ls_rdata,
    output logic [MEM_ADDR_WIDTH-1:0] mem_a,
    output logic [7:0]                mem_dout,
    output logic                      mem_wr,
    input  logic [7:0]                mem_din
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    state_t state, state_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d, mem_a_d;
    logic [2:0]  cnt, cnt_d, n_q, n_d;
    logic [31:0] data_q, data_d, asm_q, asm_d, rdata_d, mask;
    logic [7:0]  dout_d;
    logic [1:0]  idx;
    logic        abort_q, abort_d, finish_d, mem_wr_d;

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        n_d      = n_q;
        addr_d   = addr_q;
        data_d   = data_q;
        asm_d    = asm_q;
        rdata_d  = ls_rdata;
        abort_d  = abort_q;
        finish_d = 1'b0;
        mem_wr_d = 1'b0;
        mem_a_d  = mem_a;
        dout_d   = mem_dout;
        // cnt is the index of the next byte to present; the byte arriving now is cnt-1
        idx      = cnt[1:0] - 2'd1;
        mask     = n_q == 3'd1 ? 32'h0000_00FF :
                   n_q == 3'd2 ? 32'h0000_FFFF :
                   n_q == 3'd3 ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
        case (state)
            IDLE: if (en_ls) begin
                addr_d   = ls_addr[MEM_ADDR_WIDTH-1:0];
                n_d      = (ls_size != 8'd0 && ls_size <= 8'd4) ? ls_size[2:0] : 3'd4;
                data_d   = ls_data;
                cnt_d    = 3'd1;
                abort_d  = 1'b0;
                mem_a_d  = ls_addr[MEM_ADDR_WIDTH-1:0];
                mem_wr_d = ~r_nw;
                dout_d   = r_nw ? mem_dout : ls_data[7:0];
                state_d  = r_nw ? RD : WR;
            end
            RD: if (!en_ls) begin
                state_d = IDLE;
            end else begin
                asm_d[8*idx +: 8] = mem_din;
                if (cnt == n_q) begin
                    rdata_d  = asm_d & mask;
                    finish_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    mem_a_d = addr_q + MEM_ADDR_WIDTH'(cnt);
                    cnt_d   = cnt + 3'd1;
                end
            end
            WR: begin
                // a dropped request still completes its bytes so stores never tear
                abort_d = abort_q | ~en_ls;
                if (cnt == n_q) begin
                    finish_d = ~abort_d;
                    state_d  = abort_d ? IDLE : DONE;
                end else begin
                    mem_a_d  = addr_q + MEM_ADDR_WIDTH'(cnt);
                    dout_d   = data_q[8*cnt[1:0] +: 8];
                    mem_wr_d = 1'b1;
                    cnt_d    = cnt + 3'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            n_q      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            asm_q    <= '0;
            abort_q  <= 1'b0;
            finish   <= 1'b0;
            ls_rdata <= '0;
            mem_a    <= '0;
            mem_dout <= '0;
            mem_wr   <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            n_q      <= n_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            asm_q    <= asm_d;
            abort_q  <= abort_d;
            finish   <= finish_d;
            ls_rdata <= rdata_d;
            mem_a    <= mem_a_d;
            mem_dout <= dout_d;
            mem_wr   <= mem_wr_d;
        end
    end
endmodule

// File: tb/tb_ls_mem_ctrl.sv
// tb_ls_mem_ctrl: scoreboard bench for ls_mem_ctrl against a byte RAM model
module tb_ls_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_ls = 1'b0;
    logic        r_nw = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [7:0]  ls_size = '0;
    logic [31:0] ls_data = '0;
    logic        finish;
    logic [31:0] ls_rdata;
    logic [16:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;

    logic [7:0]  ram [0:(1<<17)-1];
    logic [31:0] exp_q[$];
    logic [31:0] last_rd = '0;
    int          checks = 0;
    int          errors = 0;
    int          fin_cnt = 0;

    ls_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n), .en_ls(en_ls), .r_nw(r_nw), .ls_addr(ls_addr),
        .ls_size(ls_size), .ls_data(ls_data), .finish(finish), .ls_rdata(ls_rdata),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din)
    );

    always #5 clk = ~clk;

    assign mem_din = ram[mem_a];
    always @(posedge clk) if (mem_wr) ram[mem_a] <= mem_dout;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (rst_n && finish) begin
        fin_cnt++;
        if (exp_q.size() == 0) chk("spurious_finish", 32'd1, 32'd0);
        else chk("rdata", ls_rdata, exp_q.pop_front());
    end

    // Called just after a rising edge with the DUT idle; returns just after the DONE edge.
    task automatic do_req(input logic rnw_i, input logic [31:0] a, input logic [7:0] sz,
                          input logic [31:0] d, input logic [31:0] exp, input bit hold);
        int n;
        int lat;
        n   = (sz >= 1 && sz <= 4) ? int'(sz) : 4;
        lat = 0;
        exp_q.push_back(rnw_i ? exp : last_rd);
        if (rnw_i) last_rd = exp;
        en_ls = 1'b1; r_nw = rnw_i; ls_addr = a; ls_size = sz; ls_data = d;
        @(posedge clk); #1;
        ls_addr = ~a; ls_data = ~d; ls_size = 8'd1;
        for (int k = 0; k <= 12 && lat == 0; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (finish) lat = k;
            else if (k < n) begin
                chk("mem_a", {15'd0, mem_a}, (a + k) & 32'h1FFFF);
                if (!rnw_i) begin
                    chk("mem_wr", {31'd0, mem_wr}, 32'd1);
                    chk("mem_dout", {24'd0, mem_dout}, (d >> (8*k)) & 32'hFF);
                end
            end
        end
        chk("latency", lat, n);
        if (!rnw_i) chk("wr_end", {31'd0, mem_wr}, 32'd0);
        if (!hold) en_ls = 1'b0;
        @(posedge clk); #1;
        chk("done_fin", {31'd0, finish}, 32'd0);
    endtask

    initial begin
        int f0;
        for (int i = 0; i < (1<<17); i++) ram[i] = 8'h00;
        ram['h100] = 8'h11; ram['h101] = 8'h22; ram['h102] = 8'h33; ram['h103] = 8'h44;
        ram['h205] = 8'hF0;
        ram['h1FFFF] = 8'hA1; ram[0] = 8'hB2; ram[1] = 8'hC3; ram[2] = 8'hD4;
        ram['h33] = 8'h99;
        ram['h400] = 8'h55; ram['h401] = 8'h77;
        #3;
        chk("rst_finish", {31'd0, finish}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_a", {15'd0, mem_a}, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_rdata", ls_rdata, 32'd0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(1'b1, 32'h100, 8'd4, 32'h0, 32'h44332211, 1'b0);
        do_req(1'b1, 32'h205, 8'd1, 32'h0, 32'h000000F0, 1'b0);
        do_req(1'b0, 32'h31, 8'd2, 32'hDEADBEEF, 32'h0, 1'b0);
        chk("ram_31", {24'd0, ram['h31]}, 32'hEF);
        chk("ram_32", {24'd0, ram['h32]}, 32'hBE);
        chk("ram_33", {24'd0, ram['h33]}, 32'h99);
        chk("sh_keeps_rdata", ls_rdata, 32'h000000F0);
        do_req(1'b1, 32'h31, 8'd2, 32'h0, 32'h0000BEEF, 1'b0);

        f0 = fin_cnt;
        do_req(1'b1, 32'h100, 8'd4, 32'h0, 32'h44332211, 1'b1);
        do_req(1'b0, 32'h500, 8'd4, 32'h01020304, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_finishes", fin_cnt - f0, 32'd2);
        chk("ram_503", {24'd0, ram['h503]}, 32'h01);

        do_req(1'b1, 32'h1FFFF, 8'd4, 32'h0, 32'hD4C3B2A1, 1'b0);
        do_req(1'b1, 32'h1FFFF, 8'd7, 32'h0, 32'hD4C3B2A1, 1'b0);

        f0 = fin_cnt;
        en_ls = 1'b1; r_nw = 1'b1; ls_addr = 32'h205; ls_size = 8'd4;
        @(posedge clk); #1;
        @(posedge clk); #1;
        en_ls = 1'b0;
        @(posedge clk); #1;
        chk("abort_finish", {31'd0, finish}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_fin", fin_cnt - f0, 32'd0);
        chk("abort_rdata", ls_rdata, 32'hD4C3B2A1);
        do_req(1'b1, 32'h205, 8'd1, 32'h0, 32'h000000F0, 1'b0);

        exp_q.push_back(32'hDEAD_0000);
        en_ls = 1'b1; r_nw = 1'b0; ls_addr = 32'h400; ls_size = 8'd4; ls_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_sw_wr", {31'd0, mem_wr}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("arst_finish", {31'd0, finish}, 32'd0);
        chk("arst_rdata", ls_rdata, 32'd0);
        en_ls = 1'b0;
        exp_q.delete();
        last_rd = 32'd0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(1'b1, 32'h400, 8'd2, 32'h0, 32'h0000770D, 1'b0);
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
